// File: rtl/decode_stage_ctrl_pkg.sv
// Shared definitions for the decode-stage controller: RV32I opcodes, stage
// states, the per-cycle stage action and the decoded-field bundle.
package decode_stage_ctrl_pkg;

  localparam logic [6:0] R_TYPE      = 7'b0110011;
  localparam logic [6:0] I_TYPE      = 7'b0010011;
  localparam logic [6:0] I_TYPE_LOAD = 7'b0000011;
  localparam logic [6:0] S_TYPE      = 7'b0100011;
  localparam logic [6:0] B_TYPE      = 7'b1100011;
  localparam logic [6:0] J_JAL       = 7'b1101111;
  localparam logic [6:0] I_JALR      = 7'b1100111;
  localparam logic [6:0] U_AUIPC     = 7'b0010111;
  localparam logic [6:0] U_LUI       = 7'b0110111;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // What the stage does this cycle, already resolved in priority order.
  typedef enum logic [2:0] {
    ACT_REDIRECT,
    ACT_FLUSH,
    ACT_HOLD,
    ACT_STALL,
    ACT_ADVANCE
  } action_e;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm32;
    logic        use_rs1;
    logic        use_rs2;
  } dec_t;

endpackage

// File: rtl/decode_stage_ctrl_dec.sv
// RV32I field extractor and immediate generator for the instruction held in
// IF/ID; also reports which source registers the instruction really reads.
module decode_stage_ctrl_dec
  import decode_stage_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [2:0] funct3;
  logic       sign;

  assign funct3 = instr[14:12];
  assign sign   = instr[31];

  // NOTE: every field gets a default before the case so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    dec         = '0;
    dec.rs1     = instr[19:15];
    dec.rs2     = instr[24:20];
    dec.rd      = instr[11:7];
    dec.use_rs1 = 1'b1;
    dec.use_rs2 = 1'b0;
    case (instr[6:0])
      R_TYPE: dec.use_rs2 = 1'b1;
      I_TYPE: begin
        // Shift-immediates carry a shamt, not a signed constant.
        if (funct3 == 3'b001 || funct3 == 3'b101)
          dec.imm32 = {27'b0, instr[24:20]};
        else
          dec.imm32 = {{20{sign}}, instr[31:20]};
      end
      I_TYPE_LOAD, I_JALR: dec.imm32 = {{20{sign}}, instr[31:20]};
      S_TYPE: begin
        dec.use_rs2 = 1'b1;
        dec.imm32   = {{20{sign}}, instr[31:25], instr[11:7]};
      end
      B_TYPE: begin
        dec.use_rs2 = 1'b1;
        dec.imm32   = {{19{sign}}, sign, instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      J_JAL: begin
        dec.use_rs1 = 1'b0;
        dec.imm32   = {{11{sign}}, sign, instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      U_AUIPC, U_LUI: begin
        dec.use_rs1 = 1'b0;
        dec.imm32   = {instr[31:12], 12'b0};
      end
      default: dec.imm32 = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage_ctrl.sv
// Decode-stage controller: IF/ID register, load-use stall, redirect flush,
// EX back-pressure and saturating stall/flush performance counters.
module decode_stage_ctrl
  import decode_stage_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [31:0]      if_instr,
  input  logic [31:0]      if_pc,
  output logic             if_stall,
  input  logic             ex_redirect,
  input  logic             ex_busy,
  input  logic             idex_mem_read,
  input  logic [4:0]       idex_rd,
  output logic             id_valid,
  output logic             id_bubble,
  output logic [31:0]      id_pc,
  output logic [31:0]      id_instr,
  output logic [4:0]       id_rs1,
  output logic [4:0]       id_rs2,
  output logic [4:0]       id_rd,
  output logic [31:0]      id_imm32,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

  state_e           state_q, state_d;
  logic [1:0]       flush_left_q, flush_left_d;
  logic             ifid_valid_q, ifid_valid_d;
  logic [31:0]      ifid_pc_q, ifid_pc_d;
  logic [31:0]      ifid_instr_q, ifid_instr_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  dec_t    dec;
  logic    hazard;
  action_e action;

  decode_stage_ctrl_dec u_dec (
    .instr (ifid_instr_q),
    .dec   (dec)
  );

  assign hazard = ifid_valid_q & idex_mem_read & (idex_rd != 5'd0) &
                  ((dec.use_rs1 & (idex_rd == dec.rs1)) |
                   (dec.use_rs2 & (idex_rd == dec.rs2)));

  always_comb begin
    if (ex_redirect)             action = ACT_REDIRECT;
    else if (state_q == ST_FLUSH) action = ACT_FLUSH;
    else if (ex_busy)            action = ACT_HOLD;
    else if (hazard)             action = ACT_STALL;
    else                         action = ACT_ADVANCE;
  end

  // NOTE: state and IF/ID contents are updated with non-blocking assignments
  // so every flop samples the pre-edge value of every other flop.
  // IF/ID data is reset as well so id_* show zeros rather than stale fetches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RUN;
      flush_left_q <= '0;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= '0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      flush_left_q <= flush_left_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    flush_left_d = flush_left_q;
    case (action)
      ACT_REDIRECT: begin
        if (FLUSH_CYCLES > 1) begin
          state_d      = ST_FLUSH;
          flush_left_d = FLUSH_LOAD;
        end else begin
          state_d      = ST_RUN;
        end
      end
      ACT_FLUSH: begin
        flush_left_d = flush_left_q - 2'd1;
        if (flush_left_q <= 2'd1) state_d = ST_RUN;
      end
      default: ;
    endcase
  end

  always_comb begin
    ifid_valid_d = ifid_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    case (action)
      ACT_REDIRECT: begin
        ifid_valid_d = 1'b0;
        if (!(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
      ACT_FLUSH: ifid_valid_d = 1'b0;
      ACT_STALL: if (!(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      ACT_ADVANCE: begin
        ifid_valid_d = if_valid;
        ifid_pc_d    = if_pc;
        ifid_instr_d = if_instr;
      end
      default: ;
    endcase
  end

  always_comb begin
    if_stall  = 1'b0;
    id_valid  = 1'b0;
    id_bubble = 1'b1;
    case (action)
      ACT_HOLD: begin
        if_stall  = 1'b1;
        id_valid  = ifid_valid_q;
        id_bubble = 1'b0;
      end
      ACT_STALL: if_stall = 1'b1;
      ACT_ADVANCE: begin
        id_valid  = ifid_valid_q;
        id_bubble = ~ifid_valid_q;
      end
      default: ;
    endcase
  end

  assign id_pc     = ifid_pc_q;
  assign id_instr  = ifid_instr_q;
  assign id_rs1    = dec.rs1;
  assign id_rs2    = dec.rs2;
  assign id_rd     = dec.rd;
  assign id_imm32  = dec.imm32;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_decode_stage_ctrl.sv
// Self-checking bench for decode_stage_ctrl: directed load-use, redirect,
// busy and reset scenarios followed by random traffic against a reference model.
module tb_decode_stage_ctrl;

  localparam int FC   = 2;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  logic          clk, rst;
  logic          if_valid, ex_redirect, ex_busy, idex_mem_read;
  logic [31:0]   if_instr, if_pc;
  logic [4:0]    idex_rd;
  logic          if_stall, id_valid, id_bubble;
  logic [31:0]   id_pc, id_instr, id_imm32;
  logic [4:0]    id_rs1, id_rs2, id_rd;
  logic [CW-1:0] stall_cnt, flush_cnt;

  decode_stage_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .if_stall      (if_stall),
    .ex_redirect   (ex_redirect),
    .ex_busy       (ex_busy),
    .idex_mem_read (idex_mem_read),
    .idex_rd       (idex_rd),
    .id_valid      (id_valid),
    .id_bubble     (id_bubble),
    .id_pc         (id_pc),
    .id_instr      (id_instr),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_rd         (id_rd),
    .id_imm32      (id_imm32),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: what the stage currently holds and how many more
  // fetches must still be thrown away after a redirect.
  bit          m_valid;
  logic [31:0] m_pc, m_instr;
  int          m_drop, m_stalls, m_flushes;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int sext(input int val, input int bits);
    return (val >= (1 << (bits - 1))) ? val - (1 << bits) : val;
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] x);
    int v;
    v = 0;
    case (x[6:0])
      OP_I:
        if (x[14:12] == 3'b001 || x[14:12] == 3'b101) v = int'(x[24:20]);
        else v = sext(int'(x[31:20]), 12);
      OP_LOAD, OP_JALR: v = sext(int'(x[31:20]), 12);
      OP_S:   v = sext(int'({x[31:25], x[11:7]}), 12);
      OP_B:   v = 2 * sext(int'({x[31], x[7], x[30:25], x[11:8]}), 12);
      OP_JAL: v = 2 * sext(int'({x[31], x[19:12], x[20], x[30:21]}), 20);
      OP_LUI, OP_AUIPC: v = int'(x[31:12]) * 4096;
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  function automatic bit reads_rs1(input logic [31:0] x);
    return !(x[6:0] inside {OP_LUI, OP_AUIPC, OP_JAL});
  endfunction

  function automatic bit reads_rs2(input logic [31:0] x);
    return x[6:0] inside {OP_R, OP_S, OP_B};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rd, rs1, rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, OP_R};
  endfunction

  function automatic logic [31:0] enc_i(input logic [4:0] rd, rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, OP_I};
  endfunction

  function automatic logic [31:0] enc_u(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [19:0] imm);
    return {imm, rd, op};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [10];
    logic [31:0] x;
    ops = '{OP_R, OP_I, OP_LOAD, OP_S, OP_B, OP_JAL, OP_JALR, OP_AUIPC, OP_LUI, 7'b1111111};
    x        = $urandom;
    x[6:0]   = ops[$urandom_range(0, 9)];
    x[19:15] = 5'($urandom_range(0, 7));
    x[24:20] = 5'($urandom_range(0, 7));
    return x;
  endfunction

  function automatic int sat_inc(input int n);
    return (n < CMAX) ? n + 1 : CMAX;
  endfunction

  task automatic model_reset();
    m_valid   = 1'b0;
    m_pc      = '0;
    m_instr   = '0;
    m_drop    = 0;
    m_stalls  = 0;
    m_flushes = 0;
  endtask

  // One pipeline cycle: drive inputs, compare mid-cycle, step the model, clock.
  task automatic tick(input bit v, input logic [31:0] instr, input logic [31:0] pc,
                      input bit redir, input bit busy, input bit mr, input logic [4:0] rd);
    bit hz, e_stall, e_valid, e_bubble;
    if_valid      = v;
    if_instr      = instr;
    if_pc         = pc;
    ex_redirect   = redir;
    ex_busy       = busy;
    idex_mem_read = mr;
    idex_rd       = rd;
    #2;
    check("stall_cnt", 32'(stall_cnt), 32'(m_stalls));
    check("flush_cnt", 32'(flush_cnt), 32'(m_flushes));
    if (m_valid) begin
      check("id_pc",    id_pc,           m_pc);
      check("id_instr", id_instr,        m_instr);
      check("id_rs1",   32'(id_rs1),     32'(m_instr[19:15]));
      check("id_rs2",   32'(id_rs2),     32'(m_instr[24:20]));
      check("id_rd",    32'(id_rd),      32'(m_instr[11:7]));
      check("id_imm32", id_imm32,        ref_imm(m_instr));
    end
    hz = m_valid && mr && (rd != 5'd0) &&
         ((reads_rs1(m_instr) && rd == m_instr[19:15]) ||
          (reads_rs2(m_instr) && rd == m_instr[24:20]));
    if (redir) begin
      e_stall = 0; e_valid = 0; e_bubble = 1;
      m_valid   = 1'b0;
      m_drop    = FC - 1;
      m_flushes = sat_inc(m_flushes);
    end else if (m_drop > 0) begin
      e_stall = 0; e_valid = 0; e_bubble = 1;
      m_valid = 1'b0;
      m_drop--;
    end else if (busy) begin
      e_stall = 1; e_valid = m_valid; e_bubble = 0;
    end else if (hz) begin
      e_stall = 1; e_valid = 0; e_bubble = 1;
      m_stalls = sat_inc(m_stalls);
    end else begin
      e_stall = 0; e_valid = m_valid; e_bubble = !m_valid;
      m_valid = v;
      m_pc    = pc;
      m_instr = instr;
    end
    check("if_stall",  32'(if_stall),  32'(e_stall));
    check("id_valid",  32'(id_valid),  32'(e_valid));
    check("id_bubble", 32'(id_bubble), 32'(e_bubble));
    @(posedge clk);
    #1;
  endtask

  // Raise reset between clock edges and require reset outputs before any edge.
  task automatic reset_mid(input string tag, input bit v, input logic [31:0] instr,
                           input logic [31:0] pc, input bit mr, input logic [4:0] rd);
    if_valid      = v;
    if_instr      = instr;
    if_pc         = pc;
    ex_redirect   = 1'b0;
    ex_busy       = 1'b0;
    idex_mem_read = mr;
    idex_rd       = rd;
    #2;
    rst = 1'b1;
    #1;
    check({tag, "_if_stall"},  32'(if_stall),  32'd0);
    check({tag, "_id_valid"},  32'(id_valid),  32'd0);
    check({tag, "_id_bubble"}, 32'(id_bubble), 32'd1);
    check({tag, "_stall_cnt"}, 32'(stall_cnt), 32'd0);
    check({tag, "_flush_cnt"}, 32'(flush_cnt), 32'd0);
    check({tag, "_id_pc"},     id_pc,          32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    if_valid = 0; if_instr = '0; if_pc = '0;
    ex_redirect = 0; ex_busy = 0; idex_mem_read = 0; idex_rd = '0;
    model_reset();
    #3;
    check("rst_if_stall",  32'(if_stall),  32'd0);
    check("rst_id_valid",  32'(id_valid),  32'd0);
    check("rst_id_bubble", 32'(id_bubble), 32'd1);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst_flush_cnt", 32'(flush_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // T1: lw x5 in EX, add x6,x5,x1 in ID -> one stall, then it issues.
    tick(1, enc_r(6, 5, 1), 32'h100, 0, 0, 0, 5'd0);
    tick(1, enc_i(7, 0, 12'd1), 32'h104, 0, 0, 1, 5'd5);
    check("t1_stall_cnt", 32'(stall_cnt), 32'd1);
    check("t1_held_instr", id_instr, enc_r(6, 5, 1));
    tick(1, enc_i(7, 0, 12'd1), 32'h104, 0, 0, 0, 5'd0);

    // T2: loads in EX that must not stall.
    tick(1, enc_r(6, 0, 0), 32'h108, 0, 0, 0, 5'd0);
    tick(1, enc_u(OP_LUI, 7, 20'h00028), 32'h10c, 0, 0, 1, 5'd0);
    tick(1, enc_i(8, 1, 12'd9), 32'h110, 0, 0, 1, 5'd5);
    tick(1, enc_r(1, 2, 3), 32'h114, 0, 0, 1, 5'd9);
    check("t2_stall_cnt", 32'(stall_cnt), 32'd1);

    // T3: redirect, then two fetches; the first one is discarded.
    tick(1, 32'hdeadbeef, 32'h118, 1, 0, 0, 5'd0);
    check("t3_flush_cnt", 32'(flush_cnt), 32'd1);
    tick(1, enc_i(10, 0, 12'd10), 32'h200, 0, 0, 0, 5'd0);
    tick(1, enc_i(11, 0, 12'd11), 32'h204, 0, 0, 0, 5'd0);
    tick(1, enc_i(12, 0, 12'd12), 32'h208, 0, 0, 0, 5'd0);
    check("t3_survivor_pc", id_pc, 32'h208);

    // T4: redirect coincides with busy and a load-use hazard.
    tick(1, enc_r(6, 5, 1), 32'h180, 0, 0, 0, 5'd0);
    tick(1, enc_r(7, 1, 1), 32'h184, 1, 1, 1, 5'd5);
    tick(1, enc_r(7, 1, 1), 32'h188, 0, 0, 0, 5'd0);
    tick(1, enc_r(7, 1, 1), 32'h18c, 0, 0, 0, 5'd0);

    // T5: EX busy for three cycles.
    tick(1, enc_i(3, 2, 12'h7ff), 32'h400, 0, 0, 0, 5'd0);
    for (int i = 0; i < 3; i++) tick(1, enc_i(4, 2, 12'h001), 32'h404, 0, 1, 0, 5'd0);
    tick(1, enc_i(4, 2, 12'h001), 32'h404, 0, 0, 0, 5'd0);
    check("t5_advanced_pc", id_pc, 32'h404);
    tick(0, '0, 32'h408, 0, 0, 0, 5'd0);

    // T6: asynchronous reset mid-stall and mid-flush.
    tick(1, enc_r(6, 5, 1), 32'h500, 0, 0, 0, 5'd0);
    reset_mid("t6_stall", 1, enc_i(9, 0, 12'd1), 32'h504, 1, 5'd5);
    tick(1, 32'h00500293, 32'h300, 0, 0, 0, 5'd0);
    check("t6_imm_after_stall", id_imm32, 32'd5);
    tick(1, 32'h00500293, 32'h304, 1, 0, 0, 5'd0);
    reset_mid("t6_flush", 1, enc_i(9, 0, 12'd1), 32'h308, 0, 5'd0);
    tick(1, 32'h00500293, 32'h30c, 0, 0, 0, 5'd0);
    check("t6_imm_after_flush", id_imm32, 32'd5);
    tick(0, '0, 32'h310, 0, 0, 0, 5'd0);

    // Random traffic; small counters also exercise saturation.
    for (int i = 0; i < 600; i++) begin
      tick(($urandom_range(0, 3) != 0), rand_instr(), $urandom,
           ($urandom_range(0, 11) == 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)));
    end
    check("sat_stall_cnt", 32'(stall_cnt), 32'(m_stalls));
    check("sat_flush_cnt", 32'(flush_cnt), 32'(m_flushes));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
